// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, field positions, reset PC.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_KILL = 2'd3
    } if_state_t;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Branch displacement in bytes: sign-extended word offset shifted left by two.
    function automatic logic [31:0] sext_imm_x4(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_npc_calc.sv
// Redirect decision and target PC computed from execute-stage branch/jump information.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs are pure functions of the inputs.
module npc_calc
    import inst_fetch_pkg::*;
(
    input  logic        ct_branch,
    input  logic        ct_jump,
    input  logic        alu_zero,
    input  logic [31:0] ex_pc4,
    input  logic [15:0] ex_imm16,
    input  logic [25:0] ex_jidx,
    output logic        redirect,
    output logic [31:0] target
);

    always_comb begin
        redirect = ct_jump | (ct_branch & alu_zero);
        // Jump wins when both are asserted.
        if (ct_jump) begin
            target = {ex_pc4[31:28], ex_jidx, 2'b00};
        end else begin
            target = ex_pc4 + sext_imm_x4(ex_imm16);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: requests words from imem, holds one instruction for decode, handles redirects.
// Latency: one instruction per two cycles with zero-wait memory; optional counters under IF_PERF_CNT_EN.
// Backpressure: the held instruction stays put while id_ready is low; no new request is issued until it is taken.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic [5:0]  ct_inst,
    output logic [5:0]  aluct_inst,
    input  logic        ct_branch,
    input  logic        ct_jump,
    input  logic        alu_zero,
    input  logic [31:0] ex_pc4,
    input  logic [15:0] ex_imm16,
    input  logic [25:0] ex_jidx
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] fetch_cnt
`endif
);

    if_state_t   state;
    if_state_t   state_nxt;
    logic [31:0] pc;
    logic [31:0] pc4_seq;
    logic [31:0] kill_addr;
    logic        redirect;
    logic [31:0] target;

    logic        take_inst;
    logic        pc_seq;
    logic        pc_tgt;
    logic        clr_valid;
    logic        arm_kill;

    npc_calc u_npc_calc (
        .ct_branch (ct_branch),
        .ct_jump   (ct_jump),
        .alu_zero  (alu_zero),
        .ex_pc4    (ex_pc4),
        .ex_imm16  (ex_imm16),
        .ex_jidx   (ex_jidx),
        .redirect  (redirect),
        .target    (target)
    );

    assign pc4_seq    = pc + 32'd4;
    assign ct_inst    = if_inst[OPC_MSB:OPC_LSB];
    assign aluct_inst = if_inst[FUNCT_MSB:FUNCT_LSB];

    // While killing, the abandoned request must stay on the bus even though pc has moved on.
    always_comb begin
        if (state == S_KILL) begin
            imem_addr = {kill_addr[31:2], 2'b00};
        end else begin
            imem_addr = {pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        take_inst = 1'b0;
        pc_seq    = 1'b0;
        pc_tgt    = 1'b0;
        clr_valid = 1'b0;
        arm_kill  = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
                pc_tgt    = redirect;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_tgt = 1'b1;
                    if (!imem_ack) begin
                        arm_kill  = 1'b1;
                        state_nxt = S_KILL;
                    end
                end else if (imem_ack) begin
                    take_inst = 1'b1;
                    pc_seq    = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_tgt    = 1'b1;
                    clr_valid = 1'b1;
                    state_nxt = S_REQ;
                end else if (id_ready) begin
                    clr_valid = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_KILL: begin
                imem_req = 1'b1;
                pc_tgt   = redirect;
                if (imem_ack) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            kill_addr <= RESET_PC;
            if_valid  <= 1'b0;
            if_inst   <= 32'd0;
            if_pc4    <= 32'd0;
        end else begin
            if (arm_kill) begin
                kill_addr <= pc;
            end
            if (pc_tgt) begin
                pc <= target;
            end else if (pc_seq) begin
                pc <= pc4_seq;
            end
            if (take_inst) begin
                if_inst  <= imem_rdata;
                if_pc4   <= pc4_seq;
                if_valid <= 1'b1;
            end else if (clr_valid) begin
                if_valid <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            fetch_cnt <= 32'd0;
        end else begin
            if ((state == S_HOLD) && !id_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (take_inst) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: behavioural memory, scoreboard of expected instructions, one task per scenario.
// Counter checks are compiled in when IF_PERF_CNT_EN is defined.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic [5:0]  ct_inst;
    logic [5:0]  aluct_inst;
    logic        ct_branch;
    logic        ct_jump;
    logic        alu_zero;
    logic [31:0] ex_pc4;
    logic [15:0] ex_imm16;
    logic [25:0] ex_jidx;
`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] fetch_cnt;
`endif

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_inst [$];
    logic [31:0] exp_pc4  [$];
    logic        mem_hold;
    logic        sb_mute;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_ready   (id_ready),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_pc4     (if_pc4),
        .ct_inst    (ct_inst),
        .aluct_inst (aluct_inst),
        .ct_branch  (ct_branch),
        .ct_jump    (ct_jump),
        .alu_zero   (alu_zero),
        .ex_pc4     (ex_pc4),
        .ex_imm16   (ex_imm16),
        .ex_jidx    (ex_jidx)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .fetch_cnt  (fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Zero-wait memory unless mem_hold stalls the acknowledge.
    assign imem_ack   = imem_req & ~mem_hold;
    assign imem_rdata = mem_fn(imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic observe();
        @(negedge clk);
        if (imem_req && imem_ack && !rst && !sb_mute && !(ct_jump | (ct_branch & alu_zero))) begin
            exp_inst.push_back(mem_fn(imem_addr));
            exp_pc4.push_back(imem_addr + 32'd4);
        end
    endtask

    task automatic sb_pop(output logic [31:0] i, output logic [31:0] p);
        if (exp_inst.size() == 0) begin
            i = 'x;
            p = 'x;
        end else begin
            i = exp_inst.pop_front();
            p = exp_pc4.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        observe();
        n_checks++;
        if (if_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid got %b exp 0", if_valid); end
        n_checks++;
        if (imem_req !== 1'b0) begin n_fails++; $display("FAIL reset_req got %b exp 0", imem_req); end
        n_checks++;
        if (if_inst !== 32'd0 || if_pc4 !== 32'd0) begin
            n_fails++; $display("FAIL reset_regs got inst %h pc4 %h exp 0", if_inst, if_pc4);
        end
`ifdef IF_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd0 || fetch_cnt !== 32'd0) begin
            n_fails++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, fetch_cnt);
        end
`endif
        step();
        rst = 1'b0;
        observe();
        n_checks++;
        if (imem_req !== 1'b0) begin n_fails++; $display("FAIL idle_req got %b exp 0", imem_req); end
        step();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        logic [31:0] ei;
        logic [31:0] ep;
        exp_pc = RESET_PC;
        for (int i = 0; i < 5; i++) begin
            observe();
            if (i % 2 == 0) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
                    n_fails++; $display("FAIL seq_req%0d got req %b addr %h exp 1 %h", i, imem_req, imem_addr, exp_pc);
                end
                n_checks++;
                if (if_valid !== 1'b0) begin n_fails++; $display("FAIL seq_valid%0d got %b exp 0", i, if_valid); end
                exp_pc = exp_pc + 32'd4;
            end else begin
                sb_pop(ei, ep);
                n_checks++;
                if (if_valid !== 1'b1 || imem_req !== 1'b0) begin
                    n_fails++; $display("FAIL seq_hold%0d got valid %b req %b exp 1 0", i, if_valid, imem_req);
                end
                n_checks++;
                if (if_inst !== ei || if_pc4 !== ep) begin
                    n_fails++; $display("FAIL seq_data%0d got %h %h exp %h %h", i, if_inst, if_pc4, ei, ep);
                end
                n_checks++;
                if (ct_inst !== ei[31:26] || aluct_inst !== ei[5:0]) begin
                    n_fails++; $display("FAIL seq_fields%0d got %h %h exp %h %h", i, ct_inst, aluct_inst, ei[31:26], ei[5:0]);
                end
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic [31:0] ei;
        logic [31:0] ep;
        ei = (exp_inst.size() != 0) ? exp_inst[0] : 'x;
        ep = (exp_pc4.size() != 0) ? exp_pc4[0] : 'x;
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            observe();
            n_checks++;
            if (if_valid !== 1'b1 || if_inst !== ei || if_pc4 !== ep || imem_req !== 1'b0) begin
                n_fails++; $display("FAIL stall%0d got v %b %h %h req %b exp 1 %h %h 0", i, if_valid, if_inst, if_pc4, imem_req, ei, ep);
            end
            step();
        end
        id_ready = 1'b1;
        observe();
        sb_pop(ei, ep);
        n_checks++;
        if (if_valid !== 1'b1 || if_inst !== ei || if_pc4 !== ep) begin
            n_fails++; $display("FAIL stall_release got %b %h %h exp 1 %h %h", if_valid, if_inst, if_pc4, ei, ep);
        end
`ifdef IF_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd5) begin n_fails++; $display("FAIL stall_cnt got %0d exp 5", stall_cnt); end
        n_checks++;
        if (fetch_cnt !== 32'd3) begin n_fails++; $display("FAIL fetch_cnt got %0d exp 3", fetch_cnt); end
`endif
        step();
    endtask

    task automatic test_branch();
        logic [31:0] ei;
        logic [31:0] ep;
        observe();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_000C) begin
            n_fails++; $display("FAIL br_pre_addr got %b %h exp 1 0000000c", imem_req, imem_addr);
        end
        step();
        ct_branch = 1'b1; alu_zero = 1'b1; ex_pc4 = 32'h0000_0100; ex_imm16 = 16'hFFFE;
        observe();
        sb_pop(ei, ep);
        step();
        ct_branch = 1'b0; alu_zero = 1'b0;
        observe();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_00F8 || if_valid !== 1'b0) begin
            n_fails++; $display("FAIL br_taken got req %b addr %h v %b exp 1 000000f8 0", imem_req, imem_addr, if_valid);
        end
        step();
        ct_branch = 1'b1; alu_zero = 1'b0; ex_imm16 = 16'h0040;
        observe();
        sb_pop(ei, ep);
        n_checks++;
        if (if_valid !== 1'b1 || if_inst !== ei || if_pc4 !== ep) begin
            n_fails++; $display("FAIL br_hold got %b %h %h exp 1 %h %h", if_valid, if_inst, if_pc4, ei, ep);
        end
        step();
        ct_branch = 1'b0;
    endtask

    task automatic test_jump();
        logic [31:0] ei;
        logic [31:0] ep;
        ct_jump = 1'b1; ex_pc4 = 32'h4000_0010; ex_jidx = 26'h40;
        ct_branch = 1'b1; alu_zero = 1'b1; ex_imm16 = 16'h0010;
        observe();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_00FC) begin
            n_fails++; $display("FAIL br_not_taken got %b %h exp 1 000000fc", imem_req, imem_addr);
        end
        step();
        ct_jump = 1'b0; ct_branch = 1'b0; alu_zero = 1'b0;
        observe();
        n_checks++;
        if (imem_addr !== 32'h4000_0100 || if_valid !== 1'b0) begin
            n_fails++; $display("FAIL jump_target got %h v %b exp 40000100 0", imem_addr, if_valid);
        end
        step();
        observe();
        sb_pop(ei, ep);
        n_checks++;
        if (if_valid !== 1'b1 || if_inst !== ei || if_pc4 !== 32'h4000_0104) begin
            n_fails++; $display("FAIL jump_data got %b %h %h exp 1 %h 40000104", if_valid, if_inst, if_pc4, ei);
        end
        step();
    endtask

    task automatic test_kill();
        logic [31:0] ei;
        logic [31:0] ep;
        mem_hold = 1'b1;
        ct_jump = 1'b1; ex_pc4 = 32'h0000_0200; ex_jidx = 26'h80;
        observe();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4000_0104) begin
            n_fails++; $display("FAIL kill_pre got %b %h exp 1 40000104", imem_req, imem_addr);
        end
        step();
        ct_jump = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                ct_branch = 1'b1; alu_zero = 1'b1; ex_pc4 = 32'h0000_0300; ex_imm16 = 16'h0004;
            end
            if (i == 2) begin
                ct_branch = 1'b0; alu_zero = 1'b0; mem_hold = 1'b0; sb_mute = 1'b1;
            end
            observe();
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h4000_0104 || if_valid !== 1'b0) begin
                n_fails++; $display("FAIL kill_hold%0d got %b %h v %b exp 1 40000104 0", i, imem_req, imem_addr, if_valid);
            end
            step();
        end
        sb_mute = 1'b0;
        observe();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0310 || if_valid !== 1'b0) begin
            n_fails++; $display("FAIL kill_target got %b %h v %b exp 1 00000310 0", imem_req, imem_addr, if_valid);
        end
        step();
        id_ready = 1'b0;
        observe();
        sb_pop(ei, ep);
        n_checks++;
        if (if_valid !== 1'b1 || if_inst !== ei || if_pc4 !== ep || ep !== 32'h0000_0314) begin
            n_fails++; $display("FAIL kill_data got %b %h %h exp 1 %h 00000314", if_valid, if_inst, if_pc4, ei);
        end
    endtask

    task automatic test_reset_in_hold();
        rst = 1'b1;
        ct_jump = 1'b1; ex_jidx = 26'h123;
        step();
        rst = 1'b0;
        ct_jump = 1'b0;
        exp_inst.delete();
        exp_pc4.delete();
        observe();
        n_checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0 || if_inst !== 32'd0) begin
            n_fails++; $display("FAIL rst_hold got v %b req %b inst %h exp 0 0 0", if_valid, imem_req, if_inst);
        end
`ifdef IF_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd0) begin n_fails++; $display("FAIL rst_stall_cnt got %0d exp 0", stall_cnt); end
`endif
        step();
        id_ready = 1'b1;
        observe();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            n_fails++; $display("FAIL rst_restart got %b %h exp 1 %h", imem_req, imem_addr, RESET_PC);
        end
        step();
    endtask

    initial begin
        rst = 1'b1; id_ready = 1'b1; mem_hold = 1'b0; sb_mute = 1'b0;
        ct_branch = 1'b0; ct_jump = 1'b0; alu_zero = 1'b0;
        ex_pc4 = 32'd0; ex_imm16 = 16'd0; ex_jidx = 26'd0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump();
        test_kill();
        test_reset_in_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 Port clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 Port imem_req  out  1, imem_addr  out  32  SHALL form the instruction-memory request; addr word-aligned.
REQ-005 Port imem_ack  in  1, imem_rdata  in  32  SHALL form the response; rdata valid only when ack=1.
REQ-006 Port id_ready  in  1  SHALL mean the decode/control stage accepts the held instruction this cycle.
REQ-007 Ports if_valid out 1, if_inst out 32, if_pc4 out 32 SHALL carry the held instruction and its PC+4.
REQ-008 Ports ct_inst out 6 = if_inst[31:26] and aluct_inst out 6 = if_inst[5:0] SHALL feed Control directly.
REQ-009 Ports ct_branch in 1, ct_jump in 1, alu_zero in 1, ex_pc4 in 32, ex_imm16 in 16, ex_jidx in 26 SHALL carry redirect information from execute.

Function
REQ-010 redirect SHALL be ct_jump | (ct_branch & alu_zero); ct_jump has priority over branch.
REQ-011 Branch target SHALL be ex_pc4 + (sign-extended ex_imm16 << 2), 32-bit wrap-around.
REQ-012 Jump target SHALL be {ex_pc4[31:28], ex_jidx, 2'b00}.
REQ-013 FSM states SHALL be S_IDLE, S_REQ, S_HOLD, S_KILL.
REQ-014 S_IDLE: imem_req=0; next cycle SHALL go to S_REQ.
REQ-015 S_REQ: imem_req=1, imem_addr=pc, both stable until imem_ack.
REQ-016 S_REQ & imem_ack & !redirect: capture imem_rdata into if_inst, if_pc4<=pc+4, pc<=pc+4, if_valid<=1, go S_HOLD.
REQ-017 S_HOLD & id_ready & !redirect: if_valid<=0, go S_REQ (steady-state throughput 1 instruction per 2 cycles with zero-wait memory).
REQ-018 S_HOLD & !id_ready: if_inst, if_pc4, if_valid SHALL stay unchanged.
REQ-019 redirect in S_IDLE or S_HOLD: pc<=target, if_valid<=0, go S_REQ.
REQ-020 redirect in S_REQ with imem_ack same cycle: returned data discarded, pc<=target, if_valid<=0, go S_REQ.
REQ-021 redirect in S_REQ without imem_ack: pc<=target, go S_KILL; request held at old address.
REQ-022 S_KILL: imem_req=1 at old address until ack; ack data discarded, go S_REQ at new pc; redirect in S_KILL updates pc only.
REQ-023 if_valid SHALL be 0 in S_IDLE, S_REQ, S_KILL.

Reset
REQ-024 On rst=1: state<=S_IDLE, pc<=RESET_PC, if_valid<=0, if_inst<=0, if_pc4<=0, imem_req=0.
REQ-025 rst SHALL override every other input including redirect and imem_ack; an outstanding memory ack after reset SHALL be ignored in S_IDLE.

Configuration
REQ-026 Macro IF_PERF_CNT_EN defined: add out ports stall_cnt 32 (cycles in S_HOLD with !id_ready) and fetch_cnt 32 (instructions delivered per REQ-016), both cleared by rst, wrapping at 2^32.
REQ-027 Macro IF_PERF_CNT_EN undefined: counters and ports absent; all other behaviour identical.

Structure
REQ-028 Shared package SHALL hold FSM state encoding, opcode/funct field positions, and RESET_PC default.
REQ-029 Sub-module npc_calc (combinational: redirect, target) SHALL be used; everything else in inst_fetch.

Verification
REQ-030 Reset, zero-wait memory, id_ready=1: imem_addr sequence 0,4,8; if_valid every 2nd cycle; ct_inst=if_inst[31:26].
REQ-031 In S_HOLD, id_ready=0 for 5 cycles: if_inst/if_pc4 stable; stall_cnt=5 with IF_PERF_CNT_EN.
REQ-032 ct_branch=1, alu_zero=1, ex_pc4=0x100, ex_imm16=0xFFFE: next imem_addr=0xF8.
REQ-033 ct_jump=1, ex_pc4=0x4000_0010, ex_jidx=0x40: next imem_addr=0x4000_0100.
REQ-034 Redirect in S_REQ, ack 3 cycles later: old addr held, its data dropped (if_valid=0), then request at target.
REQ-035 rst asserted in S_HOLD with id_ready=0: next cycle if_valid=0, imem_addr=RESET_PC after S_IDLE.
